fetch_pair_queue: RTL
=====================

# fetch_pair_queue

Dual-slot instruction queue between the 64-bit fetch path and the dual-issue stage. It accepts up to two 32-bit instructions per cycle from the fetch line and buffers them in program order. It presents the two oldest entries on the `fetch0_*` / `fetch1_*` slot interface consumed by the issue stage, and retires 0, 1 or 2 entries per cycle according to the issue stage's accepts. A flush empties the queue on branch redirect.

## Interface
- `DEPTH`, 8: entry count, power of two, ≥4.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `flush_i` input 1: discard all entries and the same-cycle push.
- `in_valid_i` input 1: fetch line valid.
- `in_mask_i` input 2: per-slot valid; bit0 = low word, bit1 = high word.
- `in_pc_i` input 32: PC of the low word; bits [2:0] must be 0.
- `in_instr_i` input 64: [31:0] is the instruction at `in_pc_i`; [63:32] is the instruction at `in_pc_i+4`.
- `in_accept_o` output 1: queue can take a full line this cycle.
- `fetch0_valid_o` output 1: oldest entry valid.
- `fetch0_instr_o` output 32: oldest entry instruction.
- `fetch0_pc_o` output 32: oldest entry PC.
- `fetch1_valid_o` output 1: second-oldest entry valid.
- `fetch1_instr_o` output 32: second-oldest entry instruction.
- `fetch1_pc_o` output 32: second-oldest entry PC.
- `issue0_accept_i` input 1: issue stage consumes slot 0.
- `issue1_accept_i` input 1: issue stage consumes slot 1; meaningful only together with `issue0_accept_i`.

## Operation
- **Storage:** circular buffer of `DEPTH` entries of {instr[31:0], pc[31:0]}.
  - Head and tail pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - `count` is `$clog2(DEPTH)+1` bits, range 0..`DEPTH`.
- **Push:** occurs when `in_valid_i & in_accept_o & ~flush_i`.
  - Slots with a set mask bit are written in order, low word first, at tail, tail+1.
  - PCs written: `in_pc_i` for the low word, `in_pc_i+4` for the high word.
  - `in_mask_i=2'b10` writes only the high word, with PC `in_pc_i+4`.
  - `in_mask_i=2'b00` is a no-op.
  - Push count is 0, 1 or 2.
- **Accept:** `in_accept_o = ~rst_i & (DEPTH - count >= 2)`.
  - Computed from the registered count; it takes no credit for same-cycle pops.
  - `in_valid_i` while `in_accept_o=0` is dropped; the fetch side must hold the line.
- **Slot outputs:**
  - `fetch0_valid_o = count>=1`; `fetch1_valid_o = count>=2`.
  - Data is read from head and head+1 (wrapped).
  - `instr`/`pc` are driven 0 when the corresponding valid is low.
- **Pop count:**
  - `pop = (issue0_accept_i & fetch0_valid_o) + (issue0_accept_i & issue1_accept_i & fetch1_valid_o)`.
  - `issue1_accept_i` without `issue0_accept_i` is ignored; no entry is removed.
  - An accept on an invalid slot is ignored.
- **Update:** `count_next = count + push - pop`; head advances by pop, tail by push. A simultaneous push and pop is legal at any fill level.
- **Flush:** `flush_i` has priority over push and pop. Next cycle, count=0 and head=tail=0, and the pushed line is discarded.
- **Reset:** `rst_i` has priority over `flush_i`. It clears head, tail and count; entry contents are not cleared.

## Timing
- **Reset values** (cycle after `rst_i`): both slot valids 0; all instr/pc outputs 0; `in_accept_o` 1 (it is 0 while `rst_i` is high).
- **Latency:** an entry pushed in cycle N is visible on `fetch0`/`fetch1` in cycle N+1. There is no same-cycle bypass.
- **Popping:** an entry accepted in cycle N is gone in N+1. The next entry shifts into `fetch0` in N+1.
- **Throughput:** sustained 2 instructions per cycle in and out when `DEPTH - count >= 2` and issue accepts both.
- **Full boundary:** at count=`DEPTH-1` or `DEPTH`, `in_accept_o=0` even when a pop occurs the same cycle.
- **Empty boundary:** at count=0 both valids are low. A push and zero pops gives count=push next cycle.
- **Wrap:** pointers wrap from `DEPTH-1` to 0. A two-entry push or pop straddling the wrap writes or reads entries `DEPTH-1` and 0.
- **Flush and reset mid-operation:** a flush or reset with partial issue in the same cycle loses all entries and the pop has no further effect.

## Test plan
- **Reset:** assert `rst_i` 2 cycles, with queue holding 3 entries → next cycle `fetch0_valid_o=0`, `fetch1_valid_o=0`, `fetch0_pc_o=0`, `in_accept_o=1`.
- **Push and partial pop:** push `in_pc_i=0x1000`, mask 11, instr {0x00208133, 0x00100093} → next cycle `fetch0` = (0x00100093, 0x1000) and `fetch1` = (0x00208133, 0x1004). Then accept slot 0 only → `fetch0` = (0x00208133, 0x1004) and `fetch1_valid_o=0`.
- **High-word-only push:** push mask 10 with `in_pc_i=0x2000` → single entry with PC 0x2004; `fetch1_valid_o=0`.
- **Fill to full:** `DEPTH=8`, 4 full pushes with no accepts → count 8, `in_accept_o=0`. With 1 pop and count 7, `in_accept_o` stays 0. After a 2-entry pop from count 8 → next cycle `in_accept_o=1`.
- **Wrap-around:** 200 cycles of random mask and random accepts, including `issue1_accept_i` without `issue0_accept_i`. The issued PC sequence must equal the pushed PC sequence, with no loss or duplication, and `count` never exceeds 8.
- **Flush:** flush with 5 entries queued, a same-cycle push and a same-cycle dual accept → next cycle both valids 0, count 0. The next push appears in `fetch0` one cycle later.

Source files
------------

// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue: dual-slot in-order instruction buffer between the 64-bit
// fetch line and the dual-issue stage. Takes up to two instructions per cycle,
// presents the two oldest, and retires 0..2 per cycle. Flush empties it.
module fetch_pair_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic [1:0]  in_mask_i,
  input  logic [31:0] in_pc_i,
  input  logic [63:0] in_instr_i,
  output logic        in_accept_o,
  output logic        fetch0_valid_o,
  output logic [31:0] fetch0_instr_o,
  output logic [31:0] fetch0_pc_o,
  output logic        fetch1_valid_o,
  output logic [31:0] fetch1_instr_o,
  output logic [31:0] fetch1_pc_o,
  input  logic        issue0_accept_i,
  input  logic        issue1_accept_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic [PW-1:0] head_nxt;
  logic [PW-1:0] tail_nxt;
  logic          push_en;
  logic [1:0]    push_cnt;
  logic [1:0]    pop_cnt;

  assign head_nxt = head_q + PW'(1);
  assign tail_nxt = tail_q + PW'(1);

  // Room for a full line is judged on the registered count only; a pop in the
  // same cycle earns no credit, keeping this off the issue-accept timing path.
  assign in_accept_o = ~rst_i & (count_q <= CW'(DEPTH - 2));
  assign push_en     = in_valid_i & in_accept_o & ~flush_i;

  assign fetch0_valid_o = (count_q != '0);
  assign fetch1_valid_o = (count_q >= CW'(2));

  assign fetch0_instr_o = fetch0_valid_o ? instr_mem_q[head_q]   : 32'h0;
  assign fetch0_pc_o    = fetch0_valid_o ? pc_mem_q[head_q]      : 32'h0;
  assign fetch1_instr_o = fetch1_valid_o ? instr_mem_q[head_nxt] : 32'h0;
  assign fetch1_pc_o    = fetch1_valid_o ? pc_mem_q[head_nxt]    : 32'h0;

  // Push/pop counts and next pointer/count state; flush overrides everything.
  always_comb begin
    push_cnt = 2'd0;
    if (push_en) begin
      push_cnt = {1'b0, in_mask_i[0]} + {1'b0, in_mask_i[1]};
    end
    // Slot 1 only retires alongside slot 0, so issue1 alone removes nothing.
    pop_cnt = {1'b0, issue0_accept_i & fetch0_valid_o}
            + {1'b0, issue0_accept_i & issue1_accept_i & fetch1_valid_o};
    count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
    head_d  = head_q + PW'(pop_cnt);
    tail_d  = tail_q + PW'(push_cnt);
    if (flush_i) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  // Pointer and occupancy registers; reset outranks flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: low word at tail, high word at tail+1 (or at tail when
  // the low word is absent). Contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (push_en && in_mask_i[0]) begin
      instr_mem_q[tail_q] <= in_instr_i[31:0];
      pc_mem_q[tail_q]    <= in_pc_i;
    end
    if (push_en && in_mask_i[1]) begin
      instr_mem_q[in_mask_i[0] ? tail_nxt : tail_q] <= in_instr_i[63:32];
      pc_mem_q[in_mask_i[0] ? tail_nxt : tail_q]    <= in_pc_i + 32'd4;
    end
  end

endmodule
